piso_serializer_fsm: RTL and testbench
======================================

PISO_SERIALIZER_FSM -- requirements
Module: piso_serializer_fsm

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, parallel word width (2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, bit order (1 = MSB first, 0 = LSB first).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_data  input  DATA_WIDTH  parallel word to serialize.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port stall  input  1  downstream hold request; freezes bit emission.
REQ-009 SHALL have port serial_out  output  1  current serial bit.
REQ-010 SHALL have port bit_valid  output  1  serial_out carries a new bit this cycle (drives downstream enable).
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse coincident with last bit of a frame.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, SHIFT, and PARITY (PARITY present only per REQ-025).
REQ-014 SHALL accept a word when in_valid and in_ready are both high at a rising edge (handshake).
REQ-015 SHALL assert in_ready combinationally in IDLE, and in SHIFT/PARITY only when the final bit of the frame is being emitted and stall is low.
REQ-016 SHALL register serial_out, bit_valid, frame_done; first bit appears the cycle after the handshake (latency 1).
REQ-017 SHALL emit DATA_WIDTH bits on consecutive unstalled cycles, order per MSB_FIRST, with a bit counter 0..DATA_WIDTH-1 of width $clog2(DATA_WIDTH)+1.
REQ-018 SHALL, when stall is high at an edge in SHIFT/PARITY, drive bit_valid=0 next cycle, hold serial_out, hold counter and shift register; emission resumes with the next bit the cycle after stall drops.
REQ-019 SHALL pulse frame_done with bit_valid on the final bit of the frame (last data bit, or parity bit if enabled).
REQ-020 SHALL, on a handshake during the final bit, start the next frame with no bubble (back-to-back bits).
REQ-021 SHALL return to IDLE after the final bit when no handshake occurs; bit_valid=0 in IDLE.
REQ-022 SHALL ignore in_data/in_valid when in_ready is low (no capture, no error).
REQ-023 SHALL ignore stall in IDLE.

Reset
REQ-024 SHALL on rst_n low immediately force state IDLE, counter 0, shift register 0, serial_out=0, bit_valid=0, frame_done=0, busy=0; any frame in flight is discarded and not resumed.

Configuration
REQ-025 SHALL support macro PISO_PARITY_EN: when defined, after the last data bit the FSM enters PARITY and emits one even-parity bit (XOR of the word) with bit_valid=1, frame length DATA_WIDTH+1; when undefined, PARITY state and parity logic are absent and SHIFT returns to IDLE/SHIFT directly.

Structure
REQ-026 SHALL place the state enumeration (IDLE, SHIFT, PARITY) and state-width constant in the shared fsm package.
REQ-027 SHALL be a single module; no sub-module is required.

Verification
REQ-028 DATA_WIDTH=4, MSB_FIRST=1, word 4'b1011, stall=0 -> serial_out 1,0,1,1 on four cycles after handshake, bit_valid high each, frame_done on fourth only.
REQ-029 MSB_FIRST=0, word 4'b1011 -> serial_out 1,1,0,1; busy high for exactly 4 cycles.
REQ-030 Words 4'b1011 then 4'b0110 offered back-to-back -> 8 consecutive bit_valid cycles 1,0,1,1,0,1,1,0, in_ready high only in IDLE and on bits 4 and 8.
REQ-031 Word 4'b1011, stall high for 2 cycles after second bit -> bit_valid low 2 cycles, serial_out held at 0, then 1,1 resume; frame_done on last bit.
REQ-032 rst_n low after second bit of 4'b1011 -> all outputs 0 immediately, in_ready high after release, no further bits of that word.
REQ-033 PISO_PARITY_EN defined, word 4'b1011 -> serial_out 1,0,1,1,1, frame_done on fifth bit only.

Source files
------------

// File: rtl/piso_serializer_fsm_pkg.sv
// Shared FSM definitions for the parallel-in serial-out serializer.
package piso_serializer_fsm_pkg;

    localparam int unsigned StateW = 2;

    // StParity is only reachable when PISO_PARITY_EN is defined.
    typedef enum logic [StateW-1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StParity = 2'd2
    } state_e;

endpackage

// File: rtl/piso_serializer_fsm.sv
// Parallel-in serial-out serializer with valid/ready input handshake and a
// downstream stall. Outputs are registered; the first bit leaves one cycle after
// the handshake. Define PISO_PARITY_EN to append one even-parity bit per frame.
module piso_serializer_fsm
    import piso_serializer_fsm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned MSB_FIRST  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  stall,
    output logic                  serial_out,
    output logic                  bit_valid,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(DATA_WIDTH - 1);

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic                    serial_q, serial_d;
    logic                    bv_q, bv_d;
    logic                    fd_q, fd_d;
`ifdef PISO_PARITY_EN
    logic                    parity_q, parity_d;
`endif

    logic                    last_bit;
    logic [CntW-1:0]         cnt_inc;
    logic [DATA_WIDTH-1:0]   shreg_adv;
    logic                    adv_bit;
    logic                    first_bit;
    logic                    handshake;
    logic                    do_load;

    // cnt_q indexes the data bit currently on serial_out; shreg_q keeps it at the
    // outgoing end so each advance only needs one shift.
    assign last_bit  = (cnt_q == LastIdx);
    assign cnt_inc   = cnt_q + CntW'(1);
    assign shreg_adv = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
    assign adv_bit   = (MSB_FIRST != 0) ? shreg_adv[DATA_WIDTH-1] : shreg_adv[0];
    assign first_bit = (MSB_FIRST != 0) ? in_data[DATA_WIDTH-1] : in_data[0];
    assign handshake = in_valid && in_ready;

    // Ready in idle, or while the frame's final bit is out and not stalled.
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            StIdle:   in_ready = 1'b1;
`ifdef PISO_PARITY_EN
            StShift:  in_ready = 1'b0;
            StParity: in_ready = !stall;
`else
            StShift:  in_ready = last_bit && !stall;
`endif
            default:  in_ready = 1'b0;
        endcase
    end

    // Next-state and next-output logic; a load in the final-bit cycle chains frames.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        serial_d = serial_q;
        bv_d     = 1'b0;
        fd_d     = 1'b0;
        do_load  = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                do_load = handshake;
            end
            StShift: begin
                if (!stall) begin
                    if (!last_bit) begin
                        cnt_d    = cnt_inc;
                        shreg_d  = shreg_adv;
                        serial_d = adv_bit;
                        bv_d     = 1'b1;
`ifdef PISO_PARITY_EN
                        fd_d     = 1'b0;
`else
                        fd_d     = (cnt_inc == LastIdx);
`endif
                    end else begin
`ifdef PISO_PARITY_EN
                        state_d  = StParity;
                        serial_d = parity_q;
                        bv_d     = 1'b1;
                        fd_d     = 1'b1;
`else
                        do_load  = handshake;
                        state_d  = StIdle;
                        cnt_d    = '0;
`endif
                    end
                end
            end
`ifdef PISO_PARITY_EN
            StParity: begin
                if (!stall) begin
                    do_load = handshake;
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
`endif
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (do_load) begin
            state_d  = StShift;
            cnt_d    = '0;
            shreg_d  = in_data;
            serial_d = first_bit;
            bv_d     = 1'b1;
            fd_d     = 1'b0;
`ifdef PISO_PARITY_EN
            parity_d = ^in_data;
`endif
        end
    end

    // FSM state, datapath and registered outputs; reset discards any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shreg_q  <= '0;
            serial_q <= 1'b0;
            bv_q     <= 1'b0;
            fd_q     <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            serial_q <= serial_d;
            bv_q     <= bv_d;
            fd_q     <= fd_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign serial_out = serial_q;
    assign bit_valid  = bv_q;
    assign frame_done = fd_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_piso_serializer_fsm.sv
// Bench for piso_serializer_fsm: an MSB-first and an LSB-first instance share
// stimulus; a frame-level model is compared every cycle, plus literal pins.
module tb_piso_serializer_fsm;

    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int FLEN = W + 1;
    localparam logic [15:0] A_M   = 16'b10111;
    localparam logic [15:0] A_L   = 16'b11011;
    localparam logic [5:0]  A_FD  = 6'b000010;
    localparam logic [15:0] B_M   = 16'b1011101100;
    localparam logic [15:0] B_L   = 16'b1101101100;
    localparam int          B_WT  = 4;
    localparam logic [5:0]  C_FD  = 6'b000000;
`else
    localparam int FLEN = W;
    localparam logic [15:0] A_M   = 16'b1011;
    localparam logic [15:0] A_L   = 16'b1101;
    localparam logic [5:0]  A_FD  = 6'b000100;
    localparam logic [15:0] B_M   = 16'b10110110;
    localparam logic [15:0] B_L   = 16'b11010110;
    localparam int          B_WT  = 3;
    localparam logic [5:0]  C_FD  = 6'b000001;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         stall = 1'b0;
    logic [1:0]   rdy_v, so_v, bv_v, fd_v, busy_v;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    piso_serializer_fsm #(.DATA_WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_v[0]), .stall(stall), .serial_out(so_v[0]),
        .bit_valid(bv_v[0]), .frame_done(fd_v[0]), .busy(busy_v[0])
    );

    piso_serializer_fsm #(.DATA_WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_v[1]), .stall(stall), .serial_out(so_v[1]),
        .bit_valid(bv_v[1]), .frame_done(fd_v[1]), .busy(busy_v[1])
    );

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, k, $time, act, exp);
    endtask

    // Model: a frame is the list of bits to send; emitted counts how many went out.
    logic [7:0] seq_q [2];
    int         emitted [2];
    bit         active [2];
    logic       m_out [2];
    logic       m_bv [2];
    logic       m_fd [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            seq_q[k] = '0; emitted[k] = 0; active[k] = 1'b0;
            m_out[k] = 1'b0; m_bv[k] = 1'b0; m_fd[k] = 1'b0;
        end
    end

    function automatic logic [7:0] build(input logic [W-1:0] w, input bit msb);
        logic [7:0] b = '0;
        for (int i = 0; i < W; i++) b[i] = msb ? w[W-1-i] : w[i];
`ifdef PISO_PARITY_EN
        b[W] = ^w;
`endif
        return b;
    endfunction

    function automatic bit m_ready(input int k);
        return !active[k] || (emitted[k] == FLEN && !stall);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                active[k] <= 1'b0; emitted[k] <= 0;
                m_out[k] <= 1'b0; m_bv[k] <= 1'b0; m_fd[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (active[k] && stall) begin
                    m_bv[k] <= 1'b0; m_fd[k] <= 1'b0;
                end else if (active[k] && emitted[k] < FLEN) begin
                    m_out[k]   <= seq_q[k][emitted[k]];
                    emitted[k] <= emitted[k] + 1;
                    m_bv[k]    <= 1'b1;
                    m_fd[k]    <= (emitted[k] + 1 == FLEN);
                end else if (in_valid && m_ready(k)) begin
                    seq_q[k]   <= build(in_data, k == 0);
                    m_out[k]   <= build(in_data, k == 0) >> 0 & 8'h01 ? 1'b1 : 1'b0;
                    emitted[k] <= 1;
                    active[k]  <= 1'b1;
                    m_bv[k]    <= 1'b1;
                    m_fd[k]    <= 1'b0;
                end else begin
                    active[k] <= 1'b0; m_bv[k] <= 1'b0; m_fd[k] <= 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check("serial_out", k, so_v[k], m_out[k]);
            check("bit_valid", k, bv_v[k], m_bv[k]);
            check("frame_done", k, fd_v[k], m_fd[k]);
            check("busy", k, busy_v[k], active[k]);
            check("in_ready", k, rdy_v[k], m_ready(k));
        end
    end

    // Traces collected by step() for the literal checks.
    logic [15:0] acc_m, acc_l, tr_bv, tr_so, tr_fd;
    int n_m, n_l, nbusy_l, nfd_m;

    task automatic clr();
        acc_m = '0; acc_l = '0; tr_bv = '0; tr_so = '0; tr_fd = '0;
        n_m = 0; n_l = 0; nbusy_l = 0; nfd_m = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        tr_bv = {tr_bv[14:0], bv_v[0]};
        tr_so = {tr_so[14:0], so_v[0]};
        tr_fd = {tr_fd[14:0], fd_v[0]};
        if (bv_v[0]) begin acc_m = {acc_m[14:0], so_v[0]}; n_m++; end
        if (bv_v[1]) begin acc_l = {acc_l[14:0], so_v[1]}; n_l++; end
        if (busy_v[1]) nbusy_l++;
        if (fd_v[0]) nfd_m++;
    endtask

    initial begin
        bit got;
        int waits;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_busy", 0, busy_v, 2'b00);
        check("rst_bit_valid", 0, bv_v, 2'b00);
        check("rst_serial_out", 0, so_v, 2'b00);
        check("rst_in_ready", 0, rdy_v, 2'b11);

        // Single frame 1011, no stall.
        clr();
        in_data = 4'b1011; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        check("a_bits_msb", 0, acc_m, A_M);
        check("a_bits_lsb", 1, acc_l, A_L);
        check("a_count", 0, n_m, FLEN);
        check("a_busy_cycles", 1, nbusy_l, FLEN);
        check("a_fd_count", 0, nfd_m, 1);
        check("a_fd_pos", 0, tr_fd[5:0], A_FD);

        // Back-to-back frames 1011 then 0110.
        clr();
        in_data = 4'b1011; in_valid = 1'b1;
        step();
        in_data = 4'b0110;
        got = 1'b0; waits = 0;
        while (!got && waits < 12) begin
            got = rdy_v[0];
            step();
            if (!got) waits++;
        end
        check("b_handshake", 0, got, 1'b1);
        check("b_wait", 0, waits, B_WT);
        in_valid = 1'b0;
        repeat (FLEN + 2) step();
        check("b_bits_msb", 0, acc_m, B_M);
        check("b_bits_lsb", 1, acc_l, B_L);
        check("b_count", 0, n_m, 2 * FLEN);

        // Stall for two cycles after the second bit.
        clr();
        in_data = 4'b1011; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        stall = 1'b1;
        step(); step();
        stall = 1'b0;
        step(); step();
        check("c_bv_trace", 0, tr_bv[5:0], 6'b110011);
        check("c_so_trace", 0, tr_so[5:0], 6'b100011);
        check("c_fd_trace", 0, tr_fd[5:0], C_FD);
        repeat (4) step();

        // Reset in the middle of a frame.
        clr();
        in_data = 4'b1011; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("d_serial_out", 0, so_v, 2'b00);
        check("d_bit_valid", 0, bv_v, 2'b00);
        check("d_frame_done", 0, fd_v, 2'b00);
        check("d_busy", 0, busy_v, 2'b00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("d_in_ready", 0, rdy_v, 2'b11);
        clr();
        repeat (4) step();
        check("d_no_bits", 0, n_m + n_l, 0);

        // Stall is ignored in idle; the word is still accepted.
        clr();
        stall = 1'b1; in_data = 4'b0110; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("e_first_bv", 0, bv_v, 2'b11);
        check("e_first_bits", 0, so_v, 2'b00);
        step(); step();
        stall = 1'b0;
        repeat (FLEN + 2) step();
        check("e_count", 0, n_m, FLEN);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
